// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and a saturating count of load-use bubbles.
module id_ex_pipe_reg #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RA_W  = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWriteD,
    input  logic             ALUSrcD,
    input  logic             MemWriteD,
    input  logic             ResultSrcD,
    input  logic             BranchD,
    input  logic [2:0]       ALUControlD,
    input  logic [XLEN-1:0]  RD1D,
    input  logic [XLEN-1:0]  RD2D,
    input  logic [XLEN-1:0]  ImmExtD,
    input  logic [XLEN-1:0]  PCD,
    input  logic [XLEN-1:0]  PCPlus4D,
    input  logic [RA_W-1:0]  Rs1D,
    input  logic [RA_W-1:0]  Rs2D,
    input  logic [RA_W-1:0]  RdD,
    input  logic             ValidD,
    input  logic             FlushE,
    output logic             RegWriteE,
    output logic             ALUSrcE,
    output logic             MemWriteE,
    output logic             ResultSrcE,
    output logic             BranchE,
    output logic [2:0]       ALUControlE,
    output logic [XLEN-1:0]  RD1E,
    output logic [XLEN-1:0]  RD2E,
    output logic [XLEN-1:0]  ImmExtE,
    output logic [XLEN-1:0]  PCE,
    output logic [XLEN-1:0]  PCPlus4E,
    output logic [RA_W-1:0]  Rs1E,
    output logic [RA_W-1:0]  Rs2E,
    output logic [RA_W-1:0]  RdE,
    output logic             ValidE,
    output logic             StallD,
    output logic [CNT_W-1:0] BubbleCnt
);

    logic             r_reg_write, r_alu_src, r_mem_write, r_result_src, r_branch, r_valid;
    logic [2:0]       r_alu_ctrl;
    logic [XLEN-1:0]  r_rd1, r_rd2, r_imm, r_pc, r_pc_plus4;
    logic [RA_W-1:0]  r_rs1, r_rs2, r_rd;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic w_stall;
    logic w_bubble;

    // rs2 is compared even for instructions that do not read it; the rare
    // spurious stall is cheaper than decoding operand usage here.
    always_comb begin
        w_stall  = r_valid & r_result_src & ValidD & (r_rd != '0) &
                   ((r_rd == Rs1D) | (r_rd == Rs2D));
        w_bubble = FlushE | w_stall;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg_write  <= 1'b0;
            r_alu_src    <= 1'b0;
            r_mem_write  <= 1'b0;
            r_result_src <= 1'b0;
            r_branch     <= 1'b0;
            r_valid      <= 1'b0;
            r_alu_ctrl   <= '0;
            r_rd         <= '0;
            r_rd1        <= '0;
            r_rd2        <= '0;
            r_imm        <= '0;
            r_pc         <= '0;
            r_pc_plus4   <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_bubble_cnt <= '0;
        end else begin
            // Data fields load unconditionally; they are don't-care in a bubble.
            r_rd1      <= RD1D;
            r_rd2      <= RD2D;
            r_imm      <= ImmExtD;
            r_pc       <= PCD;
            r_pc_plus4 <= PCPlus4D;
            r_rs1      <= Rs1D;
            r_rs2      <= Rs2D;
            if (w_bubble) begin
                r_reg_write  <= 1'b0;
                r_alu_src    <= 1'b0;
                r_mem_write  <= 1'b0;
                r_result_src <= 1'b0;
                r_branch     <= 1'b0;
                r_valid      <= 1'b0;
                r_alu_ctrl   <= '0;
                r_rd         <= '0;
            end else begin
                r_reg_write  <= RegWriteD;
                r_alu_src    <= ALUSrcD;
                r_mem_write  <= MemWriteD;
                r_result_src <= ResultSrcD;
                r_branch     <= BranchD;
                r_valid      <= ValidD;
                r_alu_ctrl   <= ALUControlD;
                r_rd         <= RdD;
            end
            // Only load-use bubbles are counted; a coincident flush wins.
            if (!FlushE && w_stall && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        RegWriteE   = r_reg_write;
        ALUSrcE     = r_alu_src;
        MemWriteE   = r_mem_write;
        ResultSrcE  = r_result_src;
        BranchE     = r_branch;
        ALUControlE = r_alu_ctrl;
        RD1E        = r_rd1;
        RD2E        = r_rd2;
        ImmExtE     = r_imm;
        PCE         = r_pc;
        PCPlus4E    = r_pc_plus4;
        Rs1E        = r_rs1;
        Rs2E        = r_rs2;
        RdE         = r_rd;
        ValidE      = r_valid;
        StallD      = w_stall;
        BubbleCnt   = r_bubble_cnt;
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Randomized and directed bench for id_ex_pipe_reg against an architectural
// model of the ID/EX stage (second instance with a 2-bit counter for saturation).
module tb_id_ex_pipe_reg;

    typedef struct packed {
        logic       rw, alusrc, mw, rsrc, br;
        logic [2:0] alu;
        logic [4:0] rd;
        logic       v;
    } ctrl_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        regwrite, alusrc, memwrite, resultsrc, branch, validd, flush;
    logic [2:0]  aluctl;
    logic [31:0] rd1, rd2, imm, pc, pcp4;
    logic [4:0]  rs1, rs2, rd;

    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ValidE, StallD, StallD2;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic [15:0] BubbleCnt;
    logic        u2_rw, u2_as, u2_mw, u2_rs, u2_br, u2_v;
    logic [2:0]  u2_alu;
    logic [31:0] u2_rd1, u2_rd2, u2_imm, u2_pc, u2_pcp4;
    logic [4:0]  u2_rs1, u2_rs2, u2_rd;
    logic [1:0]  BubbleCnt2;

    id_ex_pipe_reg dut (
        .clk(clk), .rst(rst),
        .RegWriteD(regwrite), .ALUSrcD(alusrc), .MemWriteD(memwrite),
        .ResultSrcD(resultsrc), .BranchD(branch), .ALUControlD(aluctl),
        .RD1D(rd1), .RD2D(rd2), .ImmExtD(imm), .PCD(pc), .PCPlus4D(pcp4),
        .Rs1D(rs1), .Rs2D(rs2), .RdD(rd), .ValidD(validd), .FlushE(flush),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE),
        .StallD(StallD), .BubbleCnt(BubbleCnt)
    );

    id_ex_pipe_reg #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .RegWriteD(regwrite), .ALUSrcD(alusrc), .MemWriteD(memwrite),
        .ResultSrcD(resultsrc), .BranchD(branch), .ALUControlD(aluctl),
        .RD1D(rd1), .RD2D(rd2), .ImmExtD(imm), .PCD(pc), .PCPlus4D(pcp4),
        .Rs1D(rs1), .Rs2D(rs2), .RdD(rd), .ValidD(validd), .FlushE(flush),
        .RegWriteE(u2_rw), .ALUSrcE(u2_as), .MemWriteE(u2_mw),
        .ResultSrcE(u2_rs), .BranchE(u2_br), .ALUControlE(u2_alu),
        .RD1E(u2_rd1), .RD2E(u2_rd2), .ImmExtE(u2_imm), .PCE(u2_pc), .PCPlus4E(u2_pcp4),
        .Rs1E(u2_rs1), .Rs2E(u2_rs2), .RdE(u2_rd), .ValidE(u2_v),
        .StallD(StallD2), .BubbleCnt(BubbleCnt2)
    );

    int n_vec = 0;
    int n_err = 0;

    // Architectural model of the execute slot.
    ctrl_t        m_c;
    logic [169:0] m_d;
    bit           m_bub;
    int           m_cnt, m_cnt2;

    function automatic ctrl_t d_c();
        return ctrl_t'({regwrite, alusrc, memwrite, resultsrc, branch, aluctl, rd, validd});
    endfunction

    function automatic logic [169:0] d_data();
        return {rd1, rd2, imm, pc, pcp4, rs1, rs2};
    endfunction

    function automatic ctrl_t dut_c();
        return ctrl_t'({RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
                        RdE, ValidE});
    endfunction

    function automatic logic [169:0] dut_data();
        return {RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E};
    endfunction

    // A load in E whose nonzero destination feeds either source of a real D instruction.
    function automatic bit model_stall();
        return m_c.v && m_c.rsrc && validd && (m_c.rd != 0) &&
               ((m_c.rd == rs1) || (m_c.rd == rs2));
    endfunction

    task automatic model_reset();
        m_c = '0; m_d = '0; m_bub = 1'b1; m_cnt = 0; m_cnt2 = 0;
    endtask

    task automatic clear_d();
        {regwrite, alusrc, memwrite, resultsrc, branch, validd, flush} = '0;
        aluctl = '0; rd1 = '0; rd2 = '0; imm = '0; pc = '0; pcp4 = '0;
        rs1 = '0; rs2 = '0; rd = '0;
    endtask

    // Advance one rising edge, update the model, return at the next falling edge.
    task automatic step();
        bit st;
        st = model_stall();
        @(posedge clk);
        m_d = d_data();
        if (flush || st) begin
            m_c = '0; m_bub = 1'b1;
        end else begin
            m_c = d_c(); m_bub = 1'b0;
        end
        if (!flush && st) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_d();
        regwrite = 1; memwrite = 1; resultsrc = 1; validd = 1; aluctl = 3'b101;
        rd1 = 32'hdead_beef; rd2 = 32'h1234; pc = 32'h400; rd = 5'd9; rs1 = 5'd9;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        #1;
        n_vec++;
        if (dut_c() !== ctrl_t'(0)) begin
            n_err++; $display("FAIL reset_ctrl got %h want 0", dut_c());
        end
        n_vec++;
        if (dut_data() !== '0) begin
            n_err++; $display("FAIL reset_data got %h want 0", dut_data());
        end
        n_vec++;
        if (BubbleCnt !== 16'd0 || StallD !== 1'b0) begin
            n_err++; $display("FAIL reset_cnt_stall got cnt=%0d stall=%b want 0/0",
                              BubbleCnt, StallD);
        end
        rst = 1'b1;
    endtask

    task automatic test_add();
        clear_d();
        regwrite = 1; validd = 1; aluctl = 3'b000; rd1 = 5; rd2 = 7; rd = 3;
        rs1 = 1; rs2 = 2; pc = 32'h100; pcp4 = 32'h104;
        step();
        n_vec++;
        if (dut_c() !== d_c() || dut_c() !== m_c) begin
            n_err++; $display("FAIL add_ctrl got %h want %h", dut_c(), m_c);
        end
        n_vec++;
        if (dut_data() !== m_d || RD1E !== 32'd5 || RD2E !== 32'd7) begin
            n_err++; $display("FAIL add_data got %h want %h", dut_data(), m_d);
        end
    endtask

    task automatic test_load_use();
        int c0;
        clear_d();
        regwrite = 1; resultsrc = 1; validd = 1; rd = 5; rs1 = 2;
        step();
        c0 = m_cnt;
        clear_d();
        regwrite = 1; validd = 1; rs1 = 1; rs2 = 5; rd = 6; rd1 = 11;
        #1;
        n_vec++;
        if (StallD !== 1'b1) begin
            n_err++; $display("FAIL lu_stall got %b want 1", StallD);
        end
        step();
        n_vec++;
        if (ValidE !== 1'b0 || RegWriteE !== 1'b0 || BubbleCnt !== 16'(c0 + 1)) begin
            n_err++; $display("FAIL lu_bubble got v=%b rw=%b cnt=%0d want 0/0/%0d",
                              ValidE, RegWriteE, BubbleCnt, c0 + 1);
        end
        n_vec++;
        if (StallD !== 1'b0) begin
            n_err++; $display("FAIL lu_release got %b want 0", StallD);
        end
        step();
        n_vec++;
        if (dut_c() !== m_c || RdE !== 5'd6 || ValidE !== 1'b1) begin
            n_err++; $display("FAIL lu_reload got %h want %h", dut_c(), m_c);
        end
    endtask

    task automatic test_x0();
        clear_d();
        resultsrc = 1; regwrite = 1; validd = 1; rd = 0;
        step();
        clear_d();
        regwrite = 1; validd = 1; rs1 = 0; rs2 = 0; rd = 4;
        #1;
        n_vec++;
        if (StallD !== 1'b0) begin
            n_err++; $display("FAIL x0_stall got %b want 0", StallD);
        end
        step();
        n_vec++;
        if (dut_c() !== m_c || ValidE !== 1'b1) begin
            n_err++; $display("FAIL x0_load got %h want %h", dut_c(), m_c);
        end
    endtask

    task automatic test_flush_priority();
        int c0;
        clear_d();
        resultsrc = 1; regwrite = 1; validd = 1; rd = 7;
        step();
        c0 = m_cnt;
        clear_d();
        memwrite = 1; validd = 1; rs1 = 7; flush = 1;
        #1;
        n_vec++;
        if (StallD !== 1'b1) begin
            n_err++; $display("FAIL flush_stall got %b want 1", StallD);
        end
        step();
        flush = 0;
        n_vec++;
        if (MemWriteE !== 1'b0 || ValidE !== 1'b0 || BubbleCnt !== 16'(c0) ||
            BubbleCnt !== 16'(m_cnt)) begin
            n_err++; $display("FAIL flush_bubble got mw=%b v=%b cnt=%0d want 0/0/%0d",
                              MemWriteE, ValidE, BubbleCnt, c0);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            clear_d();
            resultsrc = 1; regwrite = 1; validd = 1; rd = 5;
            step();
            clear_d();
            regwrite = 1; validd = 1; rs1 = 5; rd = 8;
            step();
            n_vec++;
            if (BubbleCnt2 !== want[i] || BubbleCnt2 !== 2'(m_cnt2)) begin
                n_err++; $display("FAIL sat_%0d got %0d want %0d", i, BubbleCnt2, want[i]);
            end
        end
        n_vec++;
        if (BubbleCnt !== 16'd5) begin
            n_err++; $display("FAIL sat_wide got %0d want 5", BubbleCnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            regwrite  = 1'($urandom); alusrc = 1'($urandom); memwrite = 1'($urandom);
            resultsrc = ($urandom_range(0, 1) == 0); branch = 1'($urandom);
            aluctl = 3'($urandom); validd = ($urandom_range(0, 99) < 85);
            flush = ($urandom_range(0, 99) < 10);
            rd1 = $urandom; rd2 = $urandom; imm = $urandom; pc = $urandom; pcp4 = pc + 4;
            rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
            rd = 5'($urandom_range(0, 3));
            #1;
            n_vec++;
            if (StallD !== model_stall()) begin
                n_err++; $display("FAIL rnd_stall[%0d] got %b want %b", i, StallD, model_stall());
            end
            step();
            n_vec++;
            if (dut_c() !== m_c || BubbleCnt !== 16'(m_cnt) || BubbleCnt2 !== 2'(m_cnt2)) begin
                n_err++; $display("FAIL rnd_ctrl[%0d] got %h cnt=%0d/%0d want %h cnt=%0d/%0d",
                                  i, dut_c(), BubbleCnt, BubbleCnt2, m_c, m_cnt, m_cnt2);
            end
            if (!m_bub) begin
                n_vec++;
                if (dut_data() !== m_d) begin
                    n_err++; $display("FAIL rnd_data[%0d] got %h want %h", i, dut_data(), m_d);
                end
            end
        end
        flush = 0;
    endtask

    task automatic test_async_reset();
        clear_d();
        resultsrc = 1; regwrite = 1; validd = 1; rd = 9;
        step();
        clear_d();
        regwrite = 1; validd = 1; rs2 = 9; rd = 10;
        #1;
        n_vec++;
        if (StallD !== 1'b1) begin
            n_err++; $display("FAIL ar_pre got %b want 1", StallD);
        end
        #1 rst = 1'b0;
        #1;
        n_vec++;
        if (StallD !== 1'b0 || dut_c() !== ctrl_t'(0) || BubbleCnt !== 16'd0 ||
            dut_data() !== '0) begin
            n_err++; $display("FAIL ar_clear got stall=%b ctrl=%h cnt=%0d want 0/0/0",
                              StallD, dut_c(), BubbleCnt);
        end
        @(negedge clk);
        model_reset();
        rst = 1'b1;
    endtask

    initial begin
        clear_d();
        model_reset();
        test_reset();
        test_add();
        test_load_use();
        test_x0();
        test_flush_priority();
        test_saturation();
        test_random();
        test_async_reset();
        test_add();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
ID/EX pipeline register of the pipelined RISC-V core. It sits directly downstream of the main decoder and ALU decoder and upstream of the execute stage. It captures the decode-stage control bundle and operands each cycle. It also owns load-use hazard detection, generating the fetch/decode stall and inserting the bubble itself, and keeps a saturating count of inserted bubbles.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register-address width
CNT_W, 16, bubble-counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
RegWriteD  in  1  decoder control
ALUSrcD  in  1  decoder control
MemWriteD  in  1  decoder control
ResultSrcD  in  1  decoder control (1 = load)
BranchD  in  1  decoder control
ALUControlD  in  3  ALU decoder output
RD1D  in  XLEN  register-file read data 1
RD2D  in  XLEN  register-file read data 2
ImmExtD  in  XLEN  extended immediate
PCD  in  XLEN  decode PC
PCPlus4D  in  XLEN  decode PC+4
Rs1D  in  RA_W  source register 1
Rs2D  in  RA_W  source register 2
RdD  in  RA_W  destination register
ValidD  in  1  decode slot holds a real instruction
FlushE  in  1  branch-taken flush from execute
RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE  out  1 each  registered controls
ALUControlE  out  3  registered
RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  XLEN each  registered
Rs1E, Rs2E, RdE  out  RA_W each  registered
ValidE  out  1  execute slot valid
StallD  out  1  combinational; hold PC and IF/ID
BubbleCnt  out  CNT_W  inserted-bubble counter

Behaviour:
- Reset (rst = 0, asynchronous): all outputs go to 0, including ValidE and BubbleCnt. StallD = 0 while in reset.
- Load-use detect (combinational):
  - StallD = ValidE & ResultSrcE & ValidD & (RdE != 0) & ((RdE == Rs1D) | (RdE == Rs2D)).
  - Both sources are compared unconditionally. A spurious stall on an instruction that does not use rs2 is accepted.
- Per-edge update, priority order:
  1. FlushE = 1: bubble.
  2. Else StallD = 1: bubble.
  3. Else load all D inputs into E. ValidE <= ValidD.
- Bubble definition: RegWriteE, MemWriteE, BranchE, ResultSrcE, ALUSrcE, ValidE = 0; ALUControlE = 0; RdE = 0.
  - The data fields (RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E) still load from D to keep the mux logic simple. Their values are don't-care.
- Latency: 1 cycle, D to E.
- Stall length: a load-use hazard stalls exactly one cycle. After the bubble, ValidE = 0, so StallD deasserts and the held instruction loads on the next edge.
- No double bubble: back-to-back load followed by a dependent load stalls once per dependency.
- BubbleCnt:
  - Increments by 1 on every edge where a bubble is inserted because of StallD.
  - Flush bubbles are not counted.
  - Saturates at all-ones with no wrap.
- Simultaneous FlushE and StallD: a flush bubble is inserted and the counter does not increment. StallD is still driven high that cycle; fetch-side flush logic overrides it.
- RdE = x0 as a load target never stalls.
- Reset asserted mid-stall: StallD drops immediately with the asynchronous reset, and all state clears.

Test Plan:
- Reset: drive rst = 0 with nonzero D inputs and toggle clk -> all E outputs 0, BubbleCnt = 0, StallD = 0. Release rst, apply an add (RegWriteD = 1, ALUControlD = 3'b000, RD1D = 5, RD2D = 7, RdD = 3) -> next edge E mirrors D exactly, ValidE = 1.
- Load-use: lw x5 in E (ResultSrcE = 1, RdE = 5, ValidE = 1), then add with Rs2D = 5 -> StallD = 1; next edge gives ValidE = 0, RegWriteE = 0, BubbleCnt = 1; the following edge loads the add with StallD = 0.
- No hazard on x0: lw x0 in E, next instruction has Rs1D = 0 -> StallD = 0 and the instruction loads normally.
- Flush priority: FlushE = 1 together with an active load-use stall -> bubble inserted, BubbleCnt unchanged, MemWriteE = 0.
- Counter saturation: CNT_W = 2, force 5 load-use stalls -> BubbleCnt reads 1, 2, 3, 3, 3.
- Asynchronous reset mid-operation: assert rst between clock edges while StallD = 1 -> outputs clear immediately, before the next clock edge.
